// File: rtl/frame_fetch_sched.sv
// frame_fetch_sched: turns one frame request into a sequence of AXI4 INCR
// read-address bursts. Each burst is capped at MAX_BURST beats and never
// crosses a 4 KB page. The number of bursts in flight is capped by
// snooping R-channel last beats.
//
// Handshake: a beat moves on the AR channel at a rising clk edge where
// m_axi_arvalid and m_axi_arready are both 1. While arvalid is high and
// arready is low, araddr/arlen do not change. After a handshake, arvalid
// is low for at least one cycle. An R burst completes at an edge where
// rvalid, rready and rlast are all 1.
module frame_fetch_sched #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_WIDTH       = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  line_words,
    input  logic [LEN_WIDTH-1:0]  num_lines,
    input  logic [ADDR_WIDTH-1:0] stride,
    output logic                  busy,
    output logic                  done,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic                  m_axi_rready,
    input  logic                  m_axi_rlast
);

    localparam int BPB  = DATA_WIDTH / 8;
    localparam int SIZE = $clog2(BPB);
    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
    // Wide enough for line_words and for a 4 KB page measured in beats.
    localparam int CW   = ((LEN_WIDTH > 13) ? LEN_WIDTH : 13) + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BPB - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] line_addr;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [LEN_WIDTH-1:0]  line_words_q;
    logic [LEN_WIDTH-1:0]  words_left;
    logic [LEN_WIDTH-1:0]  lines_left;
    logic [CW-1:0]         burst_beats;
    logic [OW-1:0]         outstanding;

    logic                  ar_hs;
    logic                  r_last_hs;
    logic                  can_issue;
    logic [12:0]           page_bytes;
    logic [CW-1:0]         beats_c;
    logic [LEN_WIDTH-1:0]  words_after;
    logic                  line_done;
    logic                  last_line;
    logic [ADDR_WIDTH-1:0] burst_bytes;

    assign m_axi_arid    = '0;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;

    assign ar_hs       = m_axi_arvalid & m_axi_arready;
    assign r_last_hs   = m_axi_rvalid & m_axi_rready & m_axi_rlast;
    assign can_issue   = (state == S_ISSUE) && !m_axi_arvalid &&
                         (outstanding < OW'(MAX_OUTSTANDING));
    assign page_bytes  = 13'h1000 - {1'b0, cur_addr[11:0]};
    assign words_after = words_left - LEN_WIDTH'(burst_beats);
    assign line_done   = (words_after == '0);
    assign last_line   = (lines_left == LEN_WIDTH'(1));
    assign burst_bytes = ADDR_WIDTH'(burst_beats) << SIZE;

    // Burst size: the smallest of the burst cap, the words left on this
    // line, and the beats remaining before the next 4 KB page.
    always_comb begin
        beats_c = CW'(MAX_BURST);
        if (CW'(words_left) < beats_c) beats_c = CW'(words_left);
        if (CW'(page_bytes >> SIZE) < beats_c) beats_c = CW'(page_bytes >> SIZE);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_lines == '0 || line_words == '0) state_next = S_FINISH;
                    else                                     state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy = 1'b1;
                if (ar_hs && line_done && last_line) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (outstanding == '0) state_next = S_FINISH;
            end
            S_FINISH: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Bursts in flight: up on AR handshake, down on R last beat, floored at 0
    // so stray last beats (e.g. from an aborted frame) are harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({ar_hs, r_last_hs})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   if (outstanding != '0) outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Frame latch, burst issue, and address/word bookkeeping after each AR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_addr     <= '0;
            cur_addr      <= '0;
            stride_q      <= '0;
            line_words_q  <= '0;
            words_left    <= '0;
            lines_left    <= '0;
            burst_beats   <= '0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_arvalid <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                line_addr    <= base_addr & ALIGN_MASK;
                cur_addr     <= base_addr & ALIGN_MASK;
                stride_q     <= stride & ALIGN_MASK;
                line_words_q <= line_words;
                words_left   <= line_words;
                lines_left   <= num_lines;
            end
            if (can_issue) begin
                m_axi_araddr  <= cur_addr;
                m_axi_arlen   <= 8'(beats_c - CW'(1));
                burst_beats   <= beats_c;
                m_axi_arvalid <= 1'b1;
            end else if (ar_hs) begin
                m_axi_arvalid <= 1'b0;
                if (line_done) begin
                    lines_left <= lines_left - LEN_WIDTH'(1);
                    line_addr  <= line_addr + stride_q;
                    cur_addr   <= line_addr + stride_q;
                    words_left <= line_words_q;
                end else begin
                    cur_addr   <= cur_addr + burst_bytes;
                    words_left <= words_after;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_fetch_sched.sv
// Bench for frame_fetch_sched: directed frames, scoreboard of expected AR
// bursts, a simple R-channel responder with a burst credit limit.
module tb_frame_fetch_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [11:0] line_words;
    logic [11:0] num_lines;
    logic [15:0] stride;
    logic        busy;
    logic        done;
    logic [7:0]  arid;
    logic [15:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic        rvalid;
    logic        rready;
    logic        rlast;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ar_count = 0;
    int last_rlast_cyc = 0;
    int r_credit = 0;
    int beat = 0;

    logic [23:0] exp_q[$];   // {araddr, arlen}
    int          r_q[$];     // beats per accepted burst

    frame_fetch_sched dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .line_words(line_words), .num_lines(num_lines), .stride(stride),
        .busy(busy), .done(done), .m_axi_arid(arid), .m_axi_araddr(araddr),
        .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rlast(rlast)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: check each AR handshake against the expected queue.
    always @(negedge clk) begin
        logic [23:0] e;
        if (!rst && arvalid && arready) begin
            ar_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ar: got addr 0x%0h len %0d, none expected", araddr, arlen);
            end else begin
                e = exp_q.pop_front();
                chk("ar_addr", {16'h0, araddr}, {16'h0, e[23:8]});
                chk("ar_len", {24'h0, arlen}, {24'h0, e[7:0]});
                chk("ar_id_size_burst", {19'h0, arid, arsize, arburst}, {19'h0, 8'h00, 3'd2, 2'd1});
                r_q.push_back(int'(e[7:0]) + 1);
            end
        end
        if (!rst && rvalid && rready && rlast) last_rlast_cyc = cyc;
    end

    // R responder: returns beats for accepted bursts while credit remains.
    always @(posedge clk) begin
        int tmp;
        if (rst) begin
            r_q.delete();
            beat = 0;
        end else if (rvalid && rready) begin
            if (rlast) begin
                tmp = r_q.pop_front();
                beat = 0;
                r_credit--;
            end else begin
                beat++;
            end
        end
        #1;
        if (!rst && r_q.size() > 0 && r_credit > 0) begin
            rvalid = 1'b1;
            rready = 1'b1;
            rlast  = (beat == r_q[0] - 1);
        end else begin
            rvalid = 1'b0;
            rready = 1'b0;
            rlast  = 1'b0;
        end
    end

    task automatic push_ar(input logic [15:0] a, input logic [7:0] l);
        exp_q.push_back({a, l});
    endtask

    task automatic start_frame(input logic [15:0] b, input logic [11:0] w,
                               input logic [11:0] n, input logic [15:0] s);
        @(posedge clk); #1;
        base_addr  = b;
        line_words = w;
        num_lines  = n;
        stride     = s;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input bit chk_lat);
        int n = 0;
        bit got = 1'b0;
        while (n < 3000 && !got) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else n++;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done within 3000 cycles, required a done pulse");
        end else begin
            chk("done_busy_low", {31'h0, busy}, 32'h0);
            if (chk_lat) chk("done_latency", cyc - last_rlast_cyc, 32'd2);
            @(negedge clk);
            chk("done_one_cycle", {31'h0, done}, 32'h0);
        end
        chk("exp_q_drained", exp_q.size(), 32'h0);
    endtask

    task automatic wait_ar_count(input int target);
        int n = 0;
        while (n < 1000 && ar_count < target) begin
            @(negedge clk);
            n++;
        end
        if (ar_count < target) begin
            checks++;
            failures++;
            $display("FAIL ar_wait_timeout: got %0d bursts, required %0d", ar_count, target);
        end
    endtask

    task automatic wait_arvalid();
        int n = 0;
        while (n < 1000 && !arvalid) begin
            @(posedge clk); #2;
            n++;
        end
        if (!arvalid) begin
            checks++;
            failures++;
            $display("FAIL arvalid_timeout: got arvalid 0, required 1");
        end
    endtask

    task automatic wait_rlast();
        int n = 0;
        while (n < 1000 && !(rvalid && rready && rlast)) begin
            @(posedge clk); #2;
            n++;
        end
        if (!(rvalid && rready && rlast)) begin
            checks++;
            failures++;
            $display("FAIL rlast_timeout: got no last beat, required one");
        end
    endtask

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int base;
        int dones;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        line_words = '0;
        num_lines = '0;
        stride = '0;
        arready = 1'b1;
        rvalid = 1'b0;
        rready = 1'b0;
        rlast = 1'b0;
        r_credit = 1000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_arvalid", {31'h0, arvalid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_araddr_arlen", {8'h0, araddr, arlen}, 32'h0);
        chk("rst_const", {19'h0, arid, arsize, arburst}, {19'h0, 8'h00, 3'd2, 2'd1});
        rst = 1'b0;

        // Single short line.
        push_ar(16'h0100, 8'd7);
        start_frame(16'h0100, 12'd8, 12'd1, 16'h0);
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        wait_done(1'b1);

        // Line split into max-length bursts.
        push_ar(16'h0000, 8'd15);
        push_ar(16'h0040, 8'd15);
        push_ar(16'h0080, 8'd7);
        start_frame(16'h0000, 12'd40, 12'd1, 16'h0);
        wait_done(1'b1);

        // 4 KB page split.
        push_ar(16'h0FF0, 8'd3);
        push_ar(16'h1000, 8'd11);
        start_frame(16'h0FF0, 12'd16, 12'd1, 16'h0);
        wait_done(1'b1);

        // Multi-line stride.
        push_ar(16'h1000, 8'd3);
        push_ar(16'h1200, 8'd3);
        push_ar(16'h1400, 8'd3);
        start_frame(16'h1000, 12'd4, 12'd3, 16'h0200);
        wait_done(1'b1);

        // Outstanding cap, release by one rlast, simultaneous AR + rlast.
        r_credit = 0;
        base = ar_count;
        for (int i = 0; i < 8; i++) push_ar(16'(i * 16'h0040), 8'd15);
        start_frame(16'h0000, 12'd128, 12'd1, 16'h0);
        wait_ar_count(base + 4);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("cap_count", ar_count - base, 32'd4);
        chk("cap_arvalid_low", {31'h0, arvalid}, 32'h0);
        r_credit = 1;
        wait_ar_count(base + 5);
        @(posedge clk); #2;
        arready = 1'b0;
        r_credit = 1;
        wait_arvalid();
        chk("after_rlast_count", ar_count - base, 32'd5);
        r_credit = 1;
        wait_rlast();
        arready = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("simul_count", ar_count - base, 32'd7);
        chk("simul_arvalid_low", {31'h0, arvalid}, 32'h0);
        r_credit = 1000;
        wait_done(1'b1);

        // AR stall: address and length hold while arready is low.
        push_ar(16'h2000, 8'd3);
        arready = 1'b0;
        start_frame(16'h2000, 12'd4, 12'd1, 16'h0);
        wait_arvalid();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_hold", {8'h0, arvalid, araddr, arlen[6:0]}, {8'h0, 1'b1, 16'h2000, 7'd3});
        end
        @(posedge clk); #1;
        arready = 1'b1;
        wait_done(1'b1);

        // Empty frames: no AR, immediate done.
        start_frame(16'h0500, 12'd8, 12'd0, 16'h0010);
        chk("zero_lines_busy", {31'h0, busy}, 32'h0);
        wait_done(1'b0);
        start_frame(16'h0500, 12'd0, 12'd2, 16'h0010);
        wait_done(1'b0);

        // Reset in the middle of a frame.
        r_credit = 0;
        base = ar_count;
        for (int i = 0; i < 4; i++) push_ar(16'h3000 + 16'(i * 16'h0040), 8'd15);
        start_frame(16'h3000, 12'd64, 12'd1, 16'h0);
        wait_ar_count(base + 4);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("abort_arvalid", {31'h0, arvalid}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_araddr", {16'h0, araddr}, 32'h0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", dones, 32'h0);
        chk("abort_exp_q", exp_q.size(), 32'h0);
        r_credit = 1000;

        // Recovery frame with unaligned base and stride (low bits ignored).
        push_ar(16'h0204, 8'd1);
        push_ar(16'h0214, 8'd1);
        start_frame(16'h0205, 12'd2, 12'd2, 16'h0013);
        wait_done(1'b1);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
